// File: rtl/ibex_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ibex_arb_pkg
// Brief   : Shared types and helpers for the Ibex memory-port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package ibex_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Width of an index able to address n masters.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_mem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin winner select. The request vector is
//           duplicated, bits below the pointer are masked off, and the lowest
//           remaining set bit wins; folding it back modulo NUM_REQ handles
//           the wrap without a second priority encoder.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import ibex_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    logic [2*NUM_REQ-1:0] w_mask;
    logic [2*NUM_REQ-1:0] w_dbl;
    int                   w_pos;

    // Mask the doubled request vector at the pointer and find its lowest set bit.
    always_comb begin
        for (int k = 0; k < int'(2*NUM_REQ); k++) begin
            w_mask[k] = (k >= int'(ptr));
        end
        w_dbl = {req, req} & w_mask;
        w_pos = 0;
        valid = 1'b0;
        for (int k = int'(2*NUM_REQ) - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_pos = k;
                valid = 1'b1;
            end
        end
        idx = IW'(w_pos % int'(NUM_REQ));
    end

endmodule
`default_nettype wire

// File: rtl/ibex_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ibex_mem_arbiter
// Brief   : Round-robin arbiter sharing one req/gnt/rvalid memory port among
//           NUM_REQ masters with a single outstanding transaction. The
//           winner's request is captured and held stable downstream; grant
//           and response are routed back to the owning master only.
// Revision: 1.0 - initial release
// ============================================================================
module ibex_mem_arbiter
    import ibex_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ-1:0]       we_i,
    input  logic [NUM_REQ*DW/8-1:0]  be_i,
    input  logic [NUM_REQ*AW-1:0]    addr_i,
    input  logic [NUM_REQ*DW-1:0]    wdata_i,
    output logic [NUM_REQ-1:0]       gnt_o,
    output logic [NUM_REQ-1:0]       rvalid_o,
    output logic [DW-1:0]            rdata_o,
    output logic                     err_o,
    output logic                     mst_req_o,
    output logic                     mst_we_o,
    output logic [DW/8-1:0]          mst_be_o,
    output logic [AW-1:0]            mst_addr_o,
    output logic [DW-1:0]            mst_wdata_o,
    input  logic                     mst_gnt_i,
    input  logic                     mst_rvalid_i,
    input  logic [DW-1:0]            mst_rdata_i,
    input  logic                     mst_err_i,
    output logic                     proto_err_o
);

    localparam int unsigned c_iw = idx_w(NUM_REQ);
    localparam int unsigned c_bw = DW / 8;

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [c_iw-1:0]   r_owner;
    logic [c_iw-1:0]   r_rr_ptr;
    logic              r_we;
    logic [c_bw-1:0]   r_be;
    logic [AW-1:0]     r_addr;
    logic [DW-1:0]     r_wdata;
    logic              r_proto_err;

    logic [c_iw-1:0]   w_pick_idx;
    logic              w_pick_valid;
    logic              w_complete;
    logic              w_resp_ok;
    logic              w_violation;
    logic [c_iw-1:0]   w_owner_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (c_iw)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (r_rr_ptr),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    // A response is legal while waiting for it, or together with the grant.
    always_comb begin
        w_resp_ok   = (r_state == RESP) || ((r_state == REQ) && mst_gnt_i);
        w_complete  = w_resp_ok && mst_rvalid_i;
        w_violation = (mst_rvalid_i && !w_resp_ok)
                   || ((r_state == REQ) && !req_i[r_owner]);
        w_owner_next = (r_owner == c_iw'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    end

    // Next-state logic: arbitrate, wait for grant, wait for response.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_pick_valid) w_state_next = REQ;
            REQ:     if (mst_gnt_i) w_state_next = mst_rvalid_i ? IDLE : RESP;
            RESP:    if (mst_rvalid_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, owner, pointer, capture and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && w_pick_valid) begin
                r_owner <= w_pick_idx;
                r_we    <= we_i[w_pick_idx];
                r_be    <= be_i[w_pick_idx*c_bw +: c_bw];
                r_addr  <= addr_i[w_pick_idx*AW +: AW];
                r_wdata <= wdata_i[w_pick_idx*DW +: DW];
            end
            if (w_complete) begin
                r_rr_ptr <= w_owner_next;
            end
            if (w_violation) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Downstream payload comes from the capture registers only; grant and
    // response are steered to the owner.
    always_comb begin
        gnt_o       = '0;
        rvalid_o    = '0;
        rdata_o     = '0;
        err_o       = 1'b0;
        mst_req_o   = (r_state == REQ);
        mst_we_o    = r_we;
        mst_be_o    = r_be;
        mst_addr_o  = r_addr;
        mst_wdata_o = r_wdata;
        proto_err_o = r_proto_err;
        if (r_state == REQ) begin
            gnt_o[r_owner] = mst_gnt_i;
        end
        if (w_complete) begin
            rvalid_o[r_owner] = 1'b1;
            rdata_o           = mst_rdata_i;
            err_o             = mst_err_i;
        end
    end

endmodule
`default_nettype wire
